// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg: repeat-FSM state encodings and width helper shared by the debouncer files
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debouncer_ch.sv
// key_debouncer_ch: one push-button channel: synchroniser, integrating filter, edge pulses, hold-to-repeat
module key_debouncer_ch
  import key_debouncer_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [26:0] REPEAT_DELAY    = 27'd50_000_000,
  parameter logic [26:0] REPEAT_PERIOD   = 27'd10_000_000
) (
  input  logic clk100_i,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned CW = $clog2(32'(DEBOUNCE_CYCLES) + 1);
  localparam int unsigned TW = $clog2(max_u(32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)) + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(32'(DEBOUNCE_CYCLES) - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(32'(REPEAT_DELAY) - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(32'(REPEAT_PERIOD) - 1);
  localparam bit RPT_EN = REPEAT_DELAY != 27'd0;

  logic s0, s1;
  logic [CW-1:0] cnt;
  logic acc, acc_press, acc_release;
  rpt_state_t state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic rep_n;

  assign acc         = (s1 != level_o) && (cnt == CNT_LAST);
  assign acc_press   = acc && s1;
  assign acc_release = acc && !s1;

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      s0        <= 1'b0;
      s1        <= 1'b0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      cnt       <= '0;
    end else begin
      s0        <= ~key_i;
      s1        <= s0;
      level_o   <= acc ? s1 : level_o;
      press_o   <= acc_press;
      release_o <= acc_release;
      cnt       <= (s1 == level_o || acc) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      state    <= RPT_IDLE;
      tmr      <= '0;
      repeat_o <= 1'b0;
    end else begin
      state    <= state_n;
      tmr      <= tmr_n;
      repeat_o <= rep_n;
    end
  end

  // release always wins, even on the edge where a repeat pulse would have fired
  always_comb begin
    state_n = state;
    tmr_n   = tmr + 1'b1;
    rep_n   = 1'b0;
    if (acc_release) begin
      state_n = RPT_IDLE;
      tmr_n   = '0;
    end else if (state == RPT_IDLE) begin
      tmr_n   = '0;
      state_n = (acc_press && RPT_EN) ? RPT_DELAY : RPT_IDLE;
    end else if (state == RPT_DELAY && tmr == DLY_LAST) begin
      state_n = RPT_REPEAT;
      tmr_n   = '0;
      rep_n   = 1'b1;
    end else if (state == RPT_REPEAT && tmr == PER_LAST) begin
      tmr_n   = '0;
      rep_n   = 1'b1;
    end else if (state != RPT_DELAY && state != RPT_REPEAT) begin
      state_n = RPT_IDLE;
      tmr_n   = '0;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: KEYS independent debounced push-button channels with press/release/repeat pulses
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int          KEYS            = 2,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [26:0] REPEAT_DELAY    = 27'd50_000_000,
  parameter logic [26:0] REPEAT_PERIOD   = 27'd10_000_000
) (
  input  logic            clk100_i,
  input  logic            rst_i,
  input  logic [KEYS-1:0] key_i,
  output logic [KEYS-1:0] level_o,
  output logic [KEYS-1:0] press_o,
  output logic [KEYS-1:0] release_o,
  output logic [KEYS-1:0] repeat_o
);

  for (genvar g = 0; g < KEYS; g++) begin : g_ch
    key_debouncer_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk100_i (clk100_i),
      .rst_i    (rst_i),
      .key_i    (key_i[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .repeat_o (repeat_o[g])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: randomized and directed checks of key_debouncer against a behavioural model
module tb_key_debouncer;

  localparam int KEYS = 2;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic            clk100_i = 1'b0;
  logic            rst_i    = 1'b1;
  logic [KEYS-1:0] key_i    = 2'b11;
  logic [KEYS-1:0] level_o, press_o, release_o, repeat_o;
  logic [KEYS-1:0] level_z, press_z, release_z, repeat_z;

  always #5 clk100_i = ~clk100_i;

  key_debouncer #(.KEYS(KEYS), .DEBOUNCE_CYCLES(16'(DB)), .REPEAT_DELAY(27'(RD)), .REPEAT_PERIOD(27'(RP))) dut (
    .clk100_i(clk100_i), .rst_i(rst_i), .key_i(key_i),
    .level_o(level_o), .press_o(press_o), .release_o(release_o), .repeat_o(repeat_o));

  key_debouncer #(.KEYS(KEYS), .DEBOUNCE_CYCLES(16'(DB)), .REPEAT_DELAY(27'd0), .REPEAT_PERIOD(27'(RP))) dut_z (
    .clk100_i(clk100_i), .rst_i(rst_i), .key_i(key_i),
    .level_o(level_z), .press_o(press_z), .release_o(release_z), .repeat_o(repeat_z));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a new level is accepted once the last DB synchronised samples all disagree with it;
  // repeats fire at held = RD, RD+RP, RD+2RP, ... edges after the press edge.
  logic [KEYS-1:0] m_s0, m_s1, m_lvl, m_pr, m_rl, m_rp;
  logic [DB-1:0]   win[KEYS];
  int              filled[KEYS];
  int              held[KEYS];

  always @(posedge clk100_i) begin
    for (int k = 0; k < KEYS; k++) begin
      if (rst_i) begin
        m_s0[k] = 1'b0; m_s1[k] = 1'b0; m_lvl[k] = 1'b0;
        m_pr[k] = 1'b0; m_rl[k] = 1'b0; m_rp[k] = 1'b0;
        win[k] = '0; filled[k] = 0; held[k] = 0;
      end else begin
        win[k] = {win[k][DB-2:0], m_s1[k]};
        if (filled[k] < DB) filled[k]++;
        m_pr[k] = 1'b0;
        m_rl[k] = 1'b0;
        if (filled[k] >= DB && win[k] == (m_lvl[k] ? {DB{1'b0}} : {DB{1'b1}})) begin
          m_lvl[k] = ~m_lvl[k];
          m_pr[k]  = m_lvl[k];
          m_rl[k]  = ~m_lvl[k];
          held[k]  = 0;
        end else if (m_lvl[k]) begin
          held[k]++;
        end
        m_rp[k] = m_lvl[k] && !m_pr[k] && held[k] >= RD && ((held[k] - RD) % RP) == 0;
        m_s1[k] = m_s0[k];
        m_s0[k] = ~key_i[k];
      end
    end
  end

  bit cnt_en = 0;
  int cnt_p  = 0;
  int cnt_r  = 0;

  always @(posedge clk100_i) begin
    #1;
    chk("level",   32'(level_o),   32'(m_lvl));
    chk("press",   32'(press_o),   32'(m_pr));
    chk("release", 32'(release_o), 32'(m_rl));
    chk("repeat",  32'(repeat_o),  32'(m_rp));
    chk("level_norpt",  32'(level_z),  32'(m_lvl));
    chk("repeat_norpt", 32'(repeat_z), 32'd0);
    if (press_o[0] && release_o[0]) chk("press_and_release", 32'd1, 32'd0);
    if (cnt_en) begin
      cnt_p += int'(press_o[0]);
      cnt_r += int'(release_o[0]);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk100_i);
    #1;
  endtask

  int gap;

  initial begin
    repeat (3) @(negedge clk100_i);
    chk("rst_outs", 32'({level_o, press_o, release_o, repeat_o}), 32'd0);
    rst_i = 1'b0;
    edges(4);
    chk("idle_outs", 32'({level_o, press_o, release_o, repeat_o}), 32'd0);

    @(negedge clk100_i) key_i[0] = 1'b0;
    edges(5);
    chk("lvl_edge5", 32'(level_o), 32'd0);
    edges(1);
    chk("press_edge6", 32'(press_o), 32'b01);
    chk("lvl_edge6", 32'(level_o), 32'b01);
    edges(1);
    chk("press_once", 32'(press_o), 32'd0);
    edges(9);
    chk("rpt_p10", 32'(repeat_o), 32'b01);
    edges(1);
    chk("rpt_p11", 32'(repeat_o), 32'd0);
    edges(2);
    chk("rpt_p13", 32'(repeat_o), 32'b01);
    edges(3);
    chk("rpt_p16", 32'(repeat_o), 32'b01);
    edges(14);
    @(negedge clk100_i) key_i[0] = 1'b1;
    edges(5);
    chk("rel_edge5", 32'(release_o), 32'd0);
    edges(1);
    chk("rel_edge6", 32'(release_o), 32'b01);
    chk("lvl_rel", 32'(level_o), 32'd0);
    edges(12);
    chk("rpt_after_rel", 32'(repeat_o), 32'd0);

    @(negedge clk100_i) key_i[0] = 1'b0;
    repeat (3) @(negedge clk100_i);
    key_i[0] = 1'b1;
    edges(12);
    chk("glitch_lvl", 32'(level_o), 32'd0);

    cnt_en = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk100_i) key_i[0] = i[0];
      @(negedge clk100_i);
    end
    @(negedge clk100_i) key_i[0] = 1'b0;
    edges(12);
    cnt_en = 0;
    chk("bounce_presses", 32'(cnt_p), 32'd1);
    chk("bounce_releases", 32'(cnt_r), 32'd0);
    @(negedge clk100_i) key_i[0] = 1'b1;
    edges(12);

    @(negedge clk100_i) key_i = 2'b00;
    edges(6);
    chk("dual_press", 32'(press_o), 32'b11);
    edges(3);
    @(negedge clk100_i) rst_i = 1'b1;
    edges(1);
    chk("midrst_outs", 32'({level_o, press_o, release_o, repeat_o}), 32'd0);
    @(negedge clk100_i) rst_i = 1'b0;
    edges(5);
    chk("repress_e5", 32'(press_o), 32'd0);
    edges(1);
    chk("repress_e6", 32'(press_o), 32'b11);
    @(negedge clk100_i) key_i = 2'b11;
    edges(10);

    for (int b = 0; b < 30; b++) begin
      gap = (b % 3 == 0) ? 2 : (b % 3 == 1) ? 7 : 40;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk100_i);
        for (int k = 0; k < KEYS; k++)
          if ($urandom_range(0, gap - 1) == 0) key_i[k] = ~key_i[k];
        rst_i = ($urandom_range(0, 399) == 0);
      end
    end
    @(negedge clk100_i) rst_i = 1'b0;
    edges(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
